// File: rtl/pe_array_sequencer.sv
// Sequencer for a 1-D row of processing elements: per tile, a filter preload
// phase, then round-robin row streaming, repeated for each column tile.
module pe_array_sequencer #(
  parameter int NUM_PE    = 5,
  parameter int FILT_ROWS = 3,
  parameter int LEN_W     = 5,
  parameter int TILE_W    = 5
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [LEN_W-1:0]  row_len,
  input  logic [TILE_W-1:0] col_tiles,
  input  logic              stall,
  input  logic              abort,
  output logic [NUM_PE-1:0] pe_read,
  output logic [NUM_PE-1:0] pe_start,
  output logic [NUM_PE-2:0] filt_read,
  output logic              busy,
  output logic              done,
  output logic [TILE_W-1:0] cur_tile,
  output logic [LEN_W-1:0]  cur_row
);

  localparam int IDX_W = $clog2(NUM_PE);
  localparam logic [IDX_W-1:0] LAST_PE      = IDX_W'(NUM_PE - 1);
  localparam logic [IDX_W-1:0] LAST_PRE_PE  = IDX_W'(NUM_PE - 2);
  localparam logic [LEN_W-1:0] LAST_FROW    = LEN_W'(FILT_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_START_LAST,
    S_STREAM,
    S_DONE
  } state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   pe_idx_reg;
  logic [LEN_W-1:0]   row_reg;
  logic [TILE_W-1:0]  tile_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [TILE_W-1:0]  tiles_reg;

  logic [LEN_W-1:0]   row_next;
  logic [TILE_W-1:0]  tile_next;
  logic [NUM_PE-1:0]  lane_hot;
  logic               run_ok;

  assign row_next  = row_reg + LEN_W'(1);
  assign tile_next = tile_reg + TILE_W'(1);
  assign run_ok    = !stall && !abort;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_lane
      assign lane_hot[gi] = (pe_idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      pe_idx_reg <= '0;
      row_reg    <= '0;
      tile_reg   <= '0;
      len_reg    <= '0;
      tiles_reg  <= '0;
    end else if (state_reg == S_IDLE) begin
      if (start && !abort) begin
        if (row_len == '0 || col_tiles == '0) begin
          state_reg <= S_DONE;
        end else begin
          state_reg <= S_PRELOAD;
          len_reg   <= row_len;
          tiles_reg <= col_tiles;
        end
      end
    end else if (abort) begin
      state_reg  <= S_IDLE;
      pe_idx_reg <= '0;
      row_reg    <= '0;
      tile_reg   <= '0;
    end else begin
      case (state_reg)
        S_PRELOAD: begin
          if (!stall) begin
            if (pe_idx_reg == LAST_PRE_PE) begin
              pe_idx_reg <= '0;
              if (row_reg == LAST_FROW) begin
                row_reg   <= '0;
                state_reg <= S_START_LAST;
              end else begin
                row_reg <= row_next;
              end
            end else begin
              pe_idx_reg <= pe_idx_reg + IDX_W'(1);
            end
          end
        end
        S_START_LAST: begin
          if (!stall) state_reg <= S_STREAM;
        end
        S_STREAM: begin
          if (!stall) begin
            if (pe_idx_reg == LAST_PE) begin
              pe_idx_reg <= '0;
              // Final lane of the final row closes the tile.
              if (row_next == len_reg) begin
                row_reg   <= '0;
                tile_reg  <= tile_next;
                state_reg <= (tile_next == tiles_reg) ? S_DONE : S_PRELOAD;
              end else begin
                row_reg <= row_next;
              end
            end else begin
              pe_idx_reg <= pe_idx_reg + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          state_reg  <= S_IDLE;
          pe_idx_reg <= '0;
          row_reg    <= '0;
          tile_reg   <= '0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pe_read   = '0;
    pe_start  = '0;
    filt_read = '0;
    if (run_ok) begin
      case (state_reg)
        S_PRELOAD: begin
          // The last PE has no filter lane; it shadows the second-to-last read.
          pe_read = lane_hot | {lane_hot[NUM_PE-2], {(NUM_PE-1){1'b0}}};
          if (tile_reg == '0) filt_read = lane_hot[NUM_PE-2:0];
          if (row_reg == LAST_FROW) pe_start = lane_hot;
        end
        S_START_LAST: pe_start = {1'b1, {(NUM_PE-1){1'b0}}};
        S_STREAM: begin
          pe_read  = lane_hot;
          pe_start = lane_hot;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_reg != S_IDLE);
  assign done     = (state_reg == S_DONE) && !abort;
  assign cur_tile = tile_reg;
  assign cur_row  = row_reg;

endmodule

// File: doc/pe_array_sequencer.md
Name: pe_array_sequencer

Overview:
Parametrised successor of the convolution top-level controller. It issues one-hot PE read/start strobes and filter-read strobes for a 1-D row of NUM_PE processing elements. Each output tile runs a filter preload phase followed by round-robin streaming, repeated for a configured number of column tiles. Over the previous controller it adds a start/done handshake, stall, abort, zero-length config handling and progress outputs; it sits between the input loader and the PE array.

Parameters:
NUM_PE, 5, number of processing elements (>=3)
FILT_ROWS, 3, filter rows loaded in the preload phase (>=2)
LEN_W, 5, width of row_len and the row counter
TILE_W, 5, width of col_tiles and the tile counter

Ports:
clk  in  1  clock, all state on rising edge
RST  in  1  synchronous active-high reset
start  in  1  pulse; accepted only in IDLE
row_len  in  LEN_W  streamed rows per tile; sampled with start
col_tiles  in  TILE_W  tiles per job; sampled with start
stall  in  1  freeze sequencing this cycle
abort  in  1  cancel job; return to IDLE
pe_read  out  NUM_PE  one-hot PE data-read strobe
pe_start  out  NUM_PE  PE compute-start strobe
filt_read  out  NUM_PE-1  one-hot filter-read strobe
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at job completion
cur_tile  out  TILE_W  current tile index
cur_row  out  LEN_W  current row index within the phase

Behaviour:
- Reset: state IDLE, all counters 0, all outputs 0.
- Outputs are combinational from registered state and counters.
- States:
  - IDLE -> PRELOAD on start when row_len != 0 and col_tiles != 0; row_len and col_tiles are latched.
  - IDLE -> DONE on start when either value is 0; no strobes are issued.
  - PRELOAD: pe_idx steps 0..NUM_PE-2, one per cycle; row steps 0..FILT_ROWS-1.
    - pe_read[pe_idx]=1. pe_read[NUM_PE-1] mirrors pe_read[NUM_PE-2].
    - filt_read[pe_idx]=1 only when cur_tile==0; later tiles reuse the loaded filters.
    - In row FILT_ROWS-1, pe_start[pe_idx]=1 as well.
    - After the last index of the last row -> START_LAST.
  - START_LAST (1 cycle): pe_start[NUM_PE-1]=1; all reads 0. Next state STREAM with row=0, pe_idx=0.
  - STREAM: pe_idx steps 0..NUM_PE-1 with pe_read[pe_idx]=pe_start[pe_idx]=1.
    - At pe_idx==NUM_PE-1, row increments.
    - When row reaches row_len: tile increments and row resets to 0.
    - If new tile == col_tiles -> DONE; otherwise -> PRELOAD (reload, filt_read stays 0).
  - DONE (1 cycle): done=1, busy=1 -> IDLE.
- Cycles per tile: FILT_ROWS*(NUM_PE-1) + 1 + NUM_PE*row_len.
- Start accepted on cycle T: first PRELOAD strobe at T+1; done at T + col_tiles*per_tile + 1.
- Stall: when stall=1 in PRELOAD, START_LAST or STREAM, all strobes are 0 and state and counters hold. Stall is ignored in IDLE and DONE; done is never stretched.
- Abort: when abort=1 in any non-IDLE state, go to IDLE next cycle, clear counters, no done. Strobes are 0 in the abort cycle. Abort has priority over stall; RST has priority over everything.
- start while busy: ignored; latched config is unchanged.
- start and abort in the same cycle in IDLE: abort wins; stay IDLE.
- Counter arithmetic is modulo 2^width. Because row_len and col_tiles are nonzero in PRELOAD/STREAM, compares never wrap. Maximum values are 2^LEN_W-1 and 2^TILE_W-1.
- Invariants: pe_read and filt_read are one-hot or zero in every cycle, except the PRELOAD mirror bit. pe_start has at most one bit set.

Test Plan:
- Defaults; start with row_len=4, col_tiles=1 at T -> filt_read and pe_read lanes 0..3 cycle at T+1..T+12. pe_start[0..3] asserted at T+9..T+12 and pe_start[4] at T+13. STREAM runs T+14..T+33 as 4 rounds of lanes 0..4. done pulses at T+34. busy is low at T+35.
- row_len=4, col_tiles=2 -> second PRELOAD T+34..T+45 has filt_read=0 and cur_tile=1. done at T+67.
- start with row_len=0 (col_tiles=3) -> no strobes; busy high T+1; done at T+1; IDLE at T+2.
- row_len=2, col_tiles=1; stall held 3 cycles mid-STREAM at pe_idx=2 -> strobes 0 for 3 cycles, then pe_idx=2 resumes. done moves from T+24 to T+27.
- abort during STREAM row 1 -> IDLE next cycle, no done pulse. A new start is accepted afterwards with filt_read asserted again (tile 0).
- start pulsed while busy with different config, and RST asserted mid-PRELOAD -> config unchanged and timing unaffected by the start. After RST, all outputs are 0 the next cycle.
